// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game core.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_OVER = 2'd2;

  function automatic dir_e opposite(input dir_e d);
    case (d)
      DIR_UP:   opposite = DIR_DOWN;
      DIR_DOWN: opposite = DIR_UP;
      DIR_LEFT: opposite = DIR_RIGHT;
      default:  opposite = DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_collide.sv
// Combinational self-collision check of a candidate cell against the live segments.
module snake_collide
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int XW      = 3,
  parameter int YW      = 3,
  parameter int LW      = 5
) (
  input  logic [XW-1:0]         next_x,
  input  logic [YW-1:0]         next_y,
  input  logic [MAX_LEN*XW-1:0] seg_x_flat,
  input  logic [MAX_LEN*YW-1:0] seg_y_flat,
  input  logic [LW-1:0]         length,
  input  logic                  grow,
  output logic                  hit
);

  localparam int LW1 = LW + 1;

  logic [LW:0] limit;

  // Without growth the tail vacates this step, so it is excluded.
  always_comb begin
    limit = grow ? {1'b0, length} : ({1'b0, length} - LW1'(1));
    hit   = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW1'(i) < limit && seg_x_flat[i*XW +: XW] == next_x &&
          seg_y_flat[i*YW +: YW] == next_y) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game core: segment shift register, direction control, collision and
// start/run/over sequencing, plus a registered active-low row readout.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = 8,
  parameter int GRID_H   = 8,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 3,
  parameter int INIT_Y   = 3,
  parameter int WRAP     = 1,
  parameter int XW       = $clog2(GRID_W),
  parameter int YW       = $clog2(GRID_H),
  parameter int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic              system_clk,
  input  logic              rst,
  input  logic              step,
  input  logic              start,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_left,
  input  logic              key_right,
  input  logic [XW-1:0]     food_x,
  input  logic [YW-1:0]     food_y,
  input  logic              food_valid,
  input  logic [YW-1:0]     rd_row,
  output logic [GRID_W-1:0] rd_data,
  output logic [XW-1:0]     head_x,
  output logic [YW-1:0]     head_y,
  output logic [LW-1:0]     length,
  output logic [15:0]       score,
  output logic              eaten,
  output logic              game_over,
  output logic [1:0]        state
);

  logic [XW-1:0]     seg_x_q [MAX_LEN];
  logic [XW-1:0]     seg_x_d [MAX_LEN];
  logic [YW-1:0]     seg_y_q [MAX_LEN];
  logic [YW-1:0]     seg_y_d [MAX_LEN];
  logic [LW-1:0]     length_q, length_d;
  logic [15:0]       score_q, score_d;
  logic              eaten_q, eaten_d;
  logic              over_q, over_d;
  state_t            state_q, state_d;
  dir_e              committed_q, committed_d;
  dir_e              pending_q, pending_d;
  logic [GRID_W-1:0] rd_data_q, rd_data_d;

  logic [XW-1:0]         next_x;
  logic [YW-1:0]         next_y;
  logic                  wall_hit, grow, self_hit;
  logic [MAX_LEN*XW-1:0] seg_x_flat;
  logic [MAX_LEN*YW-1:0] seg_y_flat;
  logic                  key_valid;
  dir_e                  key_dir;

  // Committed direction is loaded from pending on the step itself, so the
  // candidate head is derived from the pending direction.
  always_comb begin
    next_x   = seg_x_q[0];
    next_y   = seg_y_q[0];
    wall_hit = 1'b0;
    unique case (pending_q)
      DIR_UP: begin
        if (seg_y_q[0] == '0) begin
          next_y   = YW'(GRID_H - 1);
          wall_hit = (WRAP == 0);
        end else begin
          next_y = seg_y_q[0] - YW'(1);
        end
      end
      DIR_DOWN: begin
        if (seg_y_q[0] == YW'(GRID_H - 1)) begin
          next_y   = '0;
          wall_hit = (WRAP == 0);
        end else begin
          next_y = seg_y_q[0] + YW'(1);
        end
      end
      DIR_LEFT: begin
        if (seg_x_q[0] == '0) begin
          next_x   = XW'(GRID_W - 1);
          wall_hit = (WRAP == 0);
        end else begin
          next_x = seg_x_q[0] - XW'(1);
        end
      end
      DIR_RIGHT: begin
        if (seg_x_q[0] == XW'(GRID_W - 1)) begin
          next_x   = '0;
          wall_hit = (WRAP == 0);
        end else begin
          next_x = seg_x_q[0] + XW'(1);
        end
      end
    endcase
    grow = food_valid && !wall_hit && next_x == food_x && next_y == food_y;
  end

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_x_flat[i*XW +: XW] = seg_x_q[i];
      seg_y_flat[i*YW +: YW] = seg_y_q[i];
    end
  end

  snake_collide #(
    .MAX_LEN(MAX_LEN),
    .XW     (XW),
    .YW     (YW),
    .LW     (LW)
  ) u_collide (
    .next_x    (next_x),
    .next_y    (next_y),
    .seg_x_flat(seg_x_flat),
    .seg_y_flat(seg_y_flat),
    .length    (length_q),
    .grow      (grow),
    .hit       (self_hit)
  );

  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_RIGHT;
    if (key_up)         key_dir = DIR_UP;
    else if (key_down)  key_dir = DIR_DOWN;
    else if (key_left)  key_dir = DIR_LEFT;
    else if (key_right) key_dir = DIR_RIGHT;
    else                key_valid = 1'b0;
  end

  always_comb begin
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    length_d    = length_q;
    score_d     = score_q;
    eaten_d     = 1'b0;
    over_d      = over_q;
    state_d     = state_q;
    committed_d = committed_q;
    pending_d   = pending_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (step) begin
          committed_d = pending_q;
          if (wall_hit || self_hit) begin
            state_d = ST_OVER;
            over_d  = 1'b1;
          end else begin
            for (int i = MAX_LEN - 1; i > 0; i--) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0] = next_x;
            seg_y_d[0] = next_y;
            if (grow) begin
              if (length_q < LW'(MAX_LEN)) length_d = length_q + LW'(1);
              if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
              eaten_d = 1'b1;
            end
          end
        end
      end
      default: begin
        if (start) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = XW'(INIT_X - i);
            seg_y_d[i] = YW'(INIT_Y);
          end
          length_d    = LW'(INIT_LEN);
          score_d     = '0;
          over_d      = 1'b0;
          state_d     = ST_IDLE;
          committed_d = DIR_RIGHT;
        end
      end
    endcase

    // Reversal is judged against the direction in force after this cycle.
    if (key_valid && key_dir != opposite(committed_d)) pending_d = key_dir;
    if (state_q == ST_OVER && start) pending_d = DIR_RIGHT;
  end

  always_comb begin
    rd_data_d = '1;
    for (int x = 0; x < GRID_W; x++) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (LW'(i) < length_q && seg_y_q[i] == rd_row && seg_x_q[i] == XW'(x)) begin
          rd_data_d[x] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= XW'(INIT_X - i);
        seg_y_q[i] <= YW'(INIT_Y);
      end
      length_q    <= LW'(INIT_LEN);
      score_q     <= '0;
      eaten_q     <= 1'b0;
      over_q      <= 1'b0;
      state_q     <= ST_IDLE;
      committed_q <= DIR_RIGHT;
      pending_q   <= DIR_RIGHT;
      rd_data_q   <= '1;
    end else begin
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
      length_q    <= length_d;
      score_q     <= score_d;
      eaten_q     <= eaten_d;
      over_q      <= over_d;
      state_q     <= state_d;
      committed_q <= committed_d;
      pending_q   <= pending_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign head_x    = seg_x_q[0];
  assign head_y    = seg_y_q[0];
  assign length    = length_q;
  assign score     = score_q;
  assign eaten     = eaten_q;
  assign game_over = over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: a wrapping 16-long instance and a walled 4-long instance
// share stimulus and are each tracked by a list-based game model.
module tb_snake_engine;

  logic       system_clk = 1'b0;
  logic       rst = 1'b0, step = 1'b0, start = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic [2:0] food_x = '0, food_y = '0, rd_row = '0;
  logic       food_valid = 1'b0;

  logic [7:0]  a_rd, b_rd;
  logic [2:0]  a_hx, a_hy, b_hx, b_hy;
  logic [4:0]  a_len;
  logic [2:0]  b_len;
  logic [15:0] a_score, b_score;
  logic        a_eaten, b_eaten, a_over, b_over;
  logic [1:0]  a_state, b_state;

  always #5 system_clk = ~system_clk;

  snake_engine #(.WRAP(1)) dut_wrap (
    .system_clk(system_clk), .rst(rst), .step(step), .start(start),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .rd_row(rd_row),
    .rd_data(a_rd), .head_x(a_hx), .head_y(a_hy), .length(a_len), .score(a_score),
    .eaten(a_eaten), .game_over(a_over), .state(a_state)
  );

  snake_engine #(.MAX_LEN(4), .WRAP(0)) dut_wall (
    .system_clk(system_clk), .rst(rst), .step(step), .start(start),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .rd_row(rd_row),
    .rd_data(b_rd), .head_x(b_hx), .head_y(b_hy), .length(b_len), .score(b_score),
    .eaten(b_eaten), .game_over(b_over), .state(b_state)
  );

  // Model: live body as a coordinate list (head first); dirs 0=up 1=down 2=left 3=right.
  int m_x [2][17];
  int m_y [2][17];
  int m_len [2], m_score [2], m_eaten [2], m_state [2], m_cdir [2], m_pdir [2], m_rd [2];
  int max_len [2] = '{16, 4};
  int wrap [2] = '{1, 0};
  int n_total = 0, n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_init(input int k);
    for (int i = 0; i < 17; i++) begin
      m_x[k][i] = 3 - i;
      m_y[k][i] = 3;
    end
    m_len[k] = 3; m_score[k] = 0; m_eaten[k] = 0; m_state[k] = 0;
    m_cdir[k] = 3; m_pdir[k] = 3;
  endfunction

  function automatic void model_clock(input int k);
    int  rd, nx, ny, lim, kd;
    bit  wall, grow, hit, init_now;
    rd = 255;
    for (int i = 0; i < m_len[k]; i++)
      if (m_y[k][i] == int'(rd_row)) rd &= ~(1 << m_x[k][i]);
    m_eaten[k] = 0;
    init_now = 0;
    if (m_state[k] == 0) begin
      if (start) m_state[k] = 1;
    end else if (m_state[k] == 1) begin
      if (step) begin
        m_cdir[k] = m_pdir[k];
        nx = m_x[k][0];
        ny = m_y[k][0];
        case (m_cdir[k])
          0: ny = ny - 1;
          1: ny = ny + 1;
          2: nx = nx - 1;
          default: nx = nx + 1;
        endcase
        wall = (nx < 0) || (nx > 7) || (ny < 0) || (ny > 7);
        if (wrap[k] != 0) begin
          nx = (nx + 8) % 8;
          ny = (ny + 8) % 8;
          wall = 0;
        end
        grow = !wall && food_valid && nx == int'(food_x) && ny == int'(food_y);
        lim = grow ? m_len[k] : m_len[k] - 1;
        hit = 0;
        for (int i = 0; i < lim; i++)
          if (m_x[k][i] == nx && m_y[k][i] == ny) hit = 1;
        if (wall || hit) begin
          m_state[k] = 2;
        end else begin
          for (int i = m_len[k]; i > 0; i--) begin
            m_x[k][i] = m_x[k][i-1];
            m_y[k][i] = m_y[k][i-1];
          end
          m_x[k][0] = nx;
          m_y[k][0] = ny;
          if (grow) begin
            if (m_len[k] < max_len[k]) m_len[k]++;
            if (m_score[k] < 65535) m_score[k]++;
            m_eaten[k] = 1;
          end
        end
      end
    end else if (start) begin
      model_init(k);
      init_now = 1;
    end
    if (!init_now) begin
      kd = -1;
      if (key_up) kd = 0;
      else if (key_down) kd = 1;
      else if (key_left) kd = 2;
      else if (key_right) kd = 3;
      if (kd >= 0 && kd != (m_cdir[k] ^ 1)) m_pdir[k] = kd;
    end
    m_rd[k] = rd;
  endfunction

  task automatic check_outputs();
    check("A.state", int'(a_state), m_state[0]);
    check("A.head_x", int'(a_hx), m_x[0][0]);
    check("A.head_y", int'(a_hy), m_y[0][0]);
    check("A.length", int'(a_len), m_len[0]);
    check("A.score", int'(a_score), m_score[0]);
    check("A.eaten", int'(a_eaten), m_eaten[0]);
    check("A.game_over", int'(a_over), (m_state[0] == 2) ? 1 : 0);
    check("A.rd_data", int'(a_rd), m_rd[0]);
    check("B.state", int'(b_state), m_state[1]);
    check("B.head_x", int'(b_hx), m_x[1][0]);
    check("B.head_y", int'(b_hy), m_y[1][0]);
    check("B.length", int'(b_len), m_len[1]);
    check("B.score", int'(b_score), m_score[1]);
    check("B.eaten", int'(b_eaten), m_eaten[1]);
    check("B.game_over", int'(b_over), (m_state[1] == 2) ? 1 : 0);
    check("B.rd_data", int'(b_rd), m_rd[1]);
  endtask

  task automatic clear_in();
    step = 0; start = 0; food_valid = 0;
    {key_up, key_down, key_left, key_right} = 4'b0000;
  endtask

  task automatic tick();
    @(posedge system_clk);
    model_clock(0);
    model_clock(1);
    #1;
    check_outputs();
    clear_in();
  endtask

  // Asynchronous reset: outputs must be at init values before any clock edge.
  task automatic do_reset();
    rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_init(k);
      m_rd[k] = 255;
    end
    check_outputs();
    @(posedge system_clk);
    #1;
    check_outputs();
    rst = 0;
    clear_in();
  endtask

  task automatic step_once();
    step = 1;
    tick();
  endtask

  task automatic key_cycle(input logic [3:0] k);
    {key_up, key_down, key_left, key_right} = k;
    tick();
  endtask

  initial begin
    #2;
    do_reset();

    // Straight run, readout, wrap versus wall.
    start = 1; tick();
    repeat (3) step_once();
    rd_row = 3; tick();
    check("plan.rd_row3", int'(a_rd), 8'h8F);
    check("plan.head_x6", int'(a_hx), 6);
    check("plan.len3", int'(a_len), 3);
    step_once();
    step_once();
    check("wrap.head_x", int'(a_hx), 0);
    check("wrap.state", int'(a_state), 1);
    check("wall.state", int'(b_state), 2);
    check("wall.head_x", int'(b_hx), 7);

    // Eating and the length cap.
    do_reset();
    start = 1; tick();
    food_x = 4; food_y = 3; food_valid = 1; step_once();
    check("eat.pulse", int'(a_eaten), 1);
    check("eat.len4", int'(a_len), 4);
    check("eat.score1", int'(a_score), 1);
    tick();
    check("eat.fall", int'(a_eaten), 0);
    food_x = 5; food_valid = 1; step_once();
    check("cap.len", int'(b_len), 4);
    check("cap.score", int'(b_score), 2);
    check("cap.eaten", int'(b_eaten), 1);

    // Reversal rejection and priority of the last accepted key.
    key_cycle(4'b0010); step_once();
    check("rev.head_x", int'(a_hx), 6);
    check("rev.head_y", int'(a_hy), 3);
    key_cycle(4'b1000); key_cycle(4'b0010); step_once();
    check("upkeep.head_x", int'(a_hx), 6);
    check("upkeep.head_y", int'(a_hy), 2);

    // Square into the vacating tail, then the same path while growing.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      start = 1; tick();
      food_x = 4; food_y = 3; food_valid = 1; step_once();
      key_cycle(4'b1000); step_once();
      key_cycle(4'b0010); step_once();
      key_cycle(4'b0100);
      food_x = 3; food_y = 3; food_valid = (pass == 1); step_once();
      check("square.state", int'(a_state), pass == 0 ? 1 : 2);
      check("square.head_y", int'(a_hy), pass == 0 ? 3 : 2);
      check("square.len", int'(b_len), 4);
    end
    start = 1; tick();
    check("restart.state", int'(a_state), 0);
    check("restart.head_x", int'(a_hx), 3);
    check("restart.len", int'(a_len), 3);
    check("restart.score", int'(a_score), 0);

    // Randomised play; keys only on non-step cycles.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step  = ($urandom_range(0, 2) == 0);
        start = ($urandom_range(0, 19) == 0);
        if (!step && $urandom_range(0, 1) == 1)
          {key_up, key_down, key_left, key_right} = 4'($urandom_range(0, 15));
        food_valid = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 1) == 1) begin
          food_x = 3'(m_x[0][0] + int'($urandom_range(0, 2)) - 1);
          food_y = 3'(m_y[0][0] + int'($urandom_range(0, 2)) - 1);
        end else begin
          food_x = 3'($urandom_range(0, 7));
          food_y = 3'($urandom_range(0, 7));
        end
        rd_row = 3'($urandom_range(0, 7));
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised snake game core for the LED-matrix snake design, running entirely in the `system_clk` domain. Movement is paced by an external one-cycle `step` strobe rather than a derived clock. Over the fixed 8x8 controller it adds:
- a configurable grid;
- configurable maximum and initial length;
- wrap or wall boundary mode;
- a start/run/over state machine;
- collision prediction on the next head position;
- a registered row-readout port for the display scanner.

## Interface
Parameters:
- GRID_W, 8, grid columns (power of two when WRAP=1).
- GRID_H, 8, grid rows (power of two when WRAP=1).
- MAX_LEN, 16, maximum segment count including head.
- INIT_LEN, 3, segment count after init; 1..MAX_LEN, and INIT_LEN-1 <= INIT_X.
- INIT_X, 3, head column after init.
- INIT_Y, 3, head row after init.
- WRAP, 1, 1 = edges wrap, 0 = leaving the grid ends the game.
- XW/YW/LW, derived: $clog2(GRID_W) / $clog2(GRID_H) / $clog2(MAX_LEN+1).

Ports:
- system_clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- step  in  1  one-cycle move strobe.
- start  in  1  leave IDLE / restart from OVER.
- key_up, key_down, key_left, key_right  in  1 each  direction requests, level or pulse.
- food_x  in  XW  food column.
- food_y  in  YW  food row.
- food_valid  in  1  food present.
- rd_row  in  YW  row to read.
- rd_data  out  GRID_W  active-low row bitmap (bit x = 0 when a live segment is at (x, rd_row)); 1-cycle latency.
- head_x  out  XW  head column.
- head_y  out  YW  head row.
- length  out  LW  live segment count.
- score  out  16  foods eaten, saturating at 16'hFFFF.
- eaten  out  1  one-cycle pulse.
- game_over  out  1  high in OVER.
- state  out  2  IDLE=0, RUN=1, OVER=2.

## Operation
- Segments: segment 0 is the head. A segment i is live iff i < length; non-live segments are never displayed or compared.
- Init (reset, or start in OVER):
  - head at (INIT_X, INIT_Y); segment i at (INIT_X-i, INIT_Y);
  - length=INIT_LEN, score=0, eaten=0, game_over=0;
  - committed and pending direction = right; state=IDLE.
- FSM:
  - IDLE --start--> RUN.
  - RUN --collision on step--> OVER.
  - OVER --start--> init, then IDLE.
  - step is ignored in IDLE and OVER. start is ignored in RUN.
- Direction:
  - Every cycle, the highest-priority asserted key (up>down>left>right) loads pending_dir, unless it is the opposite of committed_dir. A rejected key leaves pending_dir unchanged and is not replaced by a lower-priority key.
  - On a RUN step, committed_dir <= pending_dir before the next head is computed. Multiple key changes between steps: the last accepted one wins.
- Next head: up y-1, down y+1, left x-1, right x+1.
  - WRAP=1: modulo grid size.
  - WRAP=0: an out-of-range result is a wall collision.
- Eat: grow = food_valid && next head == (food_x, food_y).
- Self-collision: next head equals a current segment i, for i in 0..length-2 (no grow) or 0..length-1 (grow). The vacating tail is legal to enter when not growing.
- On a RUN step:
  - With collision: state=OVER. Positions, length and score are frozen and eaten stays 0.
  - Without collision: segment i <= segment i-1 for i = 1..MAX_LEN-1, and segment 0 <= next head.
  - If grow: length <= min(length+1, MAX_LEN), score +1 (saturating), eaten=1 for that one cycle. At MAX_LEN the snake moves without growing, but score and eaten still update.
- Readout: rd_data is registered from rd_row and the live segments. All 1s in any state after init; it shows the frozen snake in OVER.

## Timing
- All outputs are registered, with reset values as given in Init.
- step sampled at cycle N: positions, length, score, eaten, state and game_over update at N+1. eaten falls at N+2.
- A key asserted in cycle N counts for a step in cycle N+1 or later; a key coincident with step applies to the following step.
- start and step in the same IDLE cycle: only the start takes effect.
- rst mid-game: immediate init, asynchronous to system_clk.
- rd_data for rd_row sampled at cycle N is valid at N+1. It reflects the segment state present at cycle N.

## Structure
- snake_pkg: direction enum (UP, DOWN, LEFT, RIGHT), state enum, opposite() function.
- Sub-module snake_collide: combinational; takes next head, segment arrays, length and grow, and returns the hit flag. It is reused by the food placer.
- Segment storage is flat XW/YW registers, MAX_LEN deep, with shift-on-step.

## Test plan
- Reset, start, 3 steps with no keys → head (6,3), length 3, rd_row=3 gives rd_data 8'b1000_1111.
- WRAP=1: head (7,3) moving right, step → head (0,3), state RUN. WRAP=0, same stimulus → state OVER, head stays (7,3).
- Food at (4,3) valid, step from (3,3) → eaten pulse for 1 cycle, length 4, score 1. Repeat to MAX_LEN=4 → length stays 4, score 2.
- Moving right, key_left then step → still moving right. Key_up then key_left before the step → up is taken.
- Length 4, turn into a square (up, left, down) → enters the vacated tail, still RUN. Same path with food on the tail cell → OVER.
- rst asserted between steps → all outputs return to init values immediately; start in OVER → IDLE with init values.
